// File: rtl/udp_tx_pkg.sv
// Shared definitions for the UDP transmit packet scheduler.
//   sched_state_t    : scheduler state encoding
//   DEF_MAX_PAYLOAD  : default maximum UDP payload per packet (bytes, even)
//   UDP_IP_HDR_BYTES : IPv4 + UDP header overhead, for upstream length checks
//   min_u32()        : unsigned minimum helper
package udp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } sched_state_t;

  localparam int unsigned DEF_MAX_PAYLOAD  = 1472;
  localparam int unsigned UDP_IP_HDR_BYTES = 28;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Loadable up-counter with synchronous clear, count enable and a
// terminal-count compare. Counting saturates at the terminal value.
//   clk, rst_n  : clock, async active-low reset
//   i_clr       : synchronous clear to zero (highest priority)
//   i_load      : load i_load_val
//   i_en        : count enable
//   i_term      : terminal count
//   o_tc_c      : combinational, count has reached i_term
module sched_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_tc_c
);

  logic [W-1:0] r_count;

  // Counter register; holds once terminal count is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && !o_tc_c) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_tc_c = (r_count >= i_term);

endmodule

// File: rtl/udp_tx_pkt_sched.sv
// Packet scheduler between the ADC transmit FIFO and the UDP/GMII transmitter.
// A restart edge arms a capture of total_bytes (forced even); the data is cut
// into packets of at most MAX_PAYLOAD bytes, each launched with a one-cycle
// pulse and a stable length, then the block waits for tx_done and an
// inter-packet gap. Partial data is flushed after FLUSH_TIMEOUT cycles.
//   clk125M, reset_n : GMII tx clock, async active-low reset
//   restart_req      : restart level; rising edge arms a capture
//   total_bytes      : capture size, sampled on the restart edge
//   fifo_rd_count    : bytes available in the FIFO
//   fifo_empty       : FIFO empty
//   tx_done          : transmitter finished current packet (pulse)
//   tx_en_pulse      : packet launch (pulse)
//   tx_length        : payload length of current packet
//   busy             : capture in progress
//   capture_done     : all bytes of the capture sent (pulse)
//   tx_err           : sticky transmitter timeout
//   pkt_count        : packets sent in current capture (wraps)
module udp_tx_pkt_sched
  import udp_tx_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD   = DEF_MAX_PAYLOAD,
  parameter int unsigned CNT_W         = 15,
  parameter int unsigned FLUSH_TIMEOUT = 125000,
  parameter int unsigned TX_TIMEOUT    = 250000,
  parameter int unsigned IFG_CYCLES    = 16
) (
  input  logic             clk125M,
  input  logic             reset_n,
  input  logic             restart_req,
  input  logic [31:0]      total_bytes,
  input  logic [CNT_W-1:0] fifo_rd_count,
  input  logic             fifo_empty,
  input  logic             tx_done,
  output logic             tx_en_pulse,
  output logic [15:0]      tx_length,
  output logic             busy,
  output logic             capture_done,
  output logic             tx_err,
  output logic [15:0]      pkt_count
);

  localparam int unsigned FLUSH_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam int unsigned TX_W    = $clog2(TX_TIMEOUT + 1);
  localparam int unsigned IFG_W   = $clog2(IFG_CYCLES + 1);

  sched_state_t r_state;
  logic         r_req_d;
  logic         r_edge;
  logic [31:0]  r_total;
  logic [31:0]  r_remaining;
  logic         r_pend;
  logic         r_zero_done;

  logic [31:0]  w_reload;
  logic [31:0]  w_chunk;
  logic [31:0]  w_rem_next;
  logic [15:0]  w_flush_len;
  logic         w_full_ok;
  logic         w_flush_fire;
  logic         w_flush_zero;
  logic         w_accept;
  logic         w_flush_clr;
  logic         w_flush_en;
  logic         w_flush_tc;
  logic         w_ifg_clr;
  logic         w_ifg_tc;
  logic         w_tx_clr;
  logic         w_tx_tc;

  // Restart is taken at once when no packet is in flight, else deferred
  assign w_accept = (r_edge && (r_state == ST_IDLE || r_state == ST_WAIT_DATA ||
                                r_state == ST_GAP)) ||
                    (r_pend && r_state == ST_IDLE);

  assign w_reload     = r_total & ~32'd1;
  assign w_chunk      = min_u32(r_remaining, 32'(MAX_PAYLOAD));
  assign w_full_ok    = (32'(fifo_rd_count) >= w_chunk);
  assign w_flush_len  = 16'({fifo_rd_count[CNT_W-1:1], 1'b0});
  assign w_flush_fire = (r_state == ST_WAIT_DATA) && !w_full_ok &&
                        (fifo_rd_count != '0) && w_flush_tc;
  assign w_flush_zero = w_flush_fire && (w_flush_len == 16'd0);
  assign w_rem_next   = r_remaining - 32'(tx_length);

  // Flush timer only runs while waiting with data present but below chunk size
  assign w_flush_clr = (r_state != ST_WAIT_DATA) || fifo_empty || w_accept || w_flush_zero;
  assign w_flush_en  = (r_state == ST_WAIT_DATA) && (fifo_rd_count != '0);
  assign w_ifg_clr   = (r_state != ST_GAP) || w_accept;
  assign w_tx_clr    = (r_state != ST_WAIT_DONE);

  sched_timer #(.W(FLUSH_W)) u_flush_timer (
    .clk        (clk125M),
    .rst_n      (reset_n),
    .i_clr      (w_flush_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_flush_en),
    .i_term     (FLUSH_W'(FLUSH_TIMEOUT)),
    .o_tc_c     (w_flush_tc)
  );

  sched_timer #(.W(IFG_W)) u_ifg_timer (
    .clk        (clk125M),
    .rst_n      (reset_n),
    .i_clr      (w_ifg_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (r_state == ST_GAP),
    .i_term     (IFG_W'(IFG_CYCLES)),
    .o_tc_c     (w_ifg_tc)
  );

  sched_timer #(.W(TX_W)) u_tx_timer (
    .clk        (clk125M),
    .rst_n      (reset_n),
    .i_clr      (w_tx_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (r_state == ST_WAIT_DONE),
    .i_term     (TX_W'(TX_TIMEOUT)),
    .o_tc_c     (w_tx_tc)
  );

  // Scheduler state machine with registered outputs
  always_ff @(posedge clk125M or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_req_d      <= 1'b0;
      r_edge       <= 1'b0;
      r_total      <= '0;
      r_remaining  <= '0;
      r_pend       <= 1'b0;
      r_zero_done  <= 1'b0;
      tx_en_pulse  <= 1'b0;
      tx_length    <= '0;
      busy         <= 1'b0;
      capture_done <= 1'b0;
      tx_err       <= 1'b0;
      pkt_count    <= '0;
    end else begin
      r_req_d     <= restart_req;
      r_edge      <= restart_req & ~r_req_d;
      if (restart_req && !r_req_d) begin
        r_total <= total_bytes;
      end
      tx_en_pulse  <= 1'b0;
      capture_done <= r_zero_done;
      r_zero_done  <= 1'b0;

      if (w_accept) begin
        r_remaining <= w_reload;
        pkt_count   <= '0;
        tx_err      <= 1'b0;
        r_pend      <= 1'b0;
        if (w_reload == 32'd0) begin
          // Empty capture completes one cycle after acceptance
          r_zero_done <= 1'b1;
          busy        <= 1'b0;
          r_state     <= ST_IDLE;
        end else begin
          busy    <= 1'b1;
          r_state <= ST_WAIT_DATA;
        end
      end else begin
        if (r_edge) begin
          r_pend <= 1'b1;
        end
        case (r_state)
          ST_WAIT_DATA: begin
            if (w_full_ok) begin
              tx_length   <= 16'(w_chunk);
              tx_en_pulse <= 1'b1;
              r_state     <= ST_LAUNCH;
            end else if (w_flush_fire && !w_flush_zero) begin
              tx_length   <= w_flush_len;
              tx_en_pulse <= 1'b1;
              r_state     <= ST_LAUNCH;
            end
          end
          ST_LAUNCH: begin
            r_state <= ST_WAIT_DONE;
          end
          ST_WAIT_DONE: begin
            if (tx_done) begin
              r_remaining <= w_rem_next;
              pkt_count   <= pkt_count + 16'd1;
              if (r_pend || r_edge) begin
                // Deferred restart is applied from IDLE on the next cycle
                r_state <= ST_IDLE;
              end else if (w_rem_next == 32'd0) begin
                capture_done <= 1'b1;
                busy         <= 1'b0;
                r_state      <= ST_IDLE;
              end else begin
                r_state <= ST_GAP;
              end
            end else if (w_tx_tc) begin
              // A restart latched during a lost packet is dropped so the fault stays visible
              tx_err  <= 1'b1;
              busy    <= 1'b0;
              r_pend  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
          ST_GAP: begin
            if (w_ifg_tc) begin
              r_state <= ST_WAIT_DATA;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_pkt_sched.sv
// Self-checking bench for udp_tx_pkt_sched (timeouts shortened for simulation).
module tb_udp_tx_pkt_sched;

  localparam int unsigned MAXP     = 1472;
  localparam int unsigned CNTW     = 15;
  localparam int unsigned FLUSH_TO = 300;
  localparam int unsigned TX_TO    = 500;
  localparam int unsigned IFG      = 16;

  logic            clk125M;
  logic            reset_n;
  logic            restart_req;
  logic [31:0]     total_bytes;
  logic [CNTW-1:0] fifo_rd_count;
  logic            fifo_empty;
  logic            tx_done;
  logic            tx_en_pulse;
  logic [15:0]     tx_length;
  logic            busy;
  logic            capture_done;
  logic            tx_err;
  logic [15:0]     pkt_count;

  udp_tx_pkt_sched #(
    .MAX_PAYLOAD   (MAXP),
    .CNT_W         (CNTW),
    .FLUSH_TIMEOUT (FLUSH_TO),
    .TX_TIMEOUT    (TX_TO),
    .IFG_CYCLES    (IFG)
  ) dut (
    .clk125M       (clk125M),
    .reset_n       (reset_n),
    .restart_req   (restart_req),
    .total_bytes   (total_bytes),
    .fifo_rd_count (fifo_rd_count),
    .fifo_empty    (fifo_empty),
    .tx_done       (tx_done),
    .tx_en_pulse   (tx_en_pulse),
    .tx_length     (tx_length),
    .busy          (busy),
    .capture_done  (capture_done),
    .tx_err        (tx_err),
    .pkt_count     (pkt_count)
  );

  initial clk125M = 1'b0;
  always #4 clk125M = ~clk125M;

  int          n_cmp;
  int          n_bad;
  int          cyc;
  int unsigned launch_q[$];
  int          launch_cyc_q[$];
  int          cd_count;
  int          last_done;
  int          min_gap;
  bit          resp_en;
  int          resp_delay;
  int          resp_cnt;
  int unsigned exp_q[$];

  typedef struct {
    int unsigned total;
    int unsigned fifo;
    int unsigned exp_pkts;
    int unsigned exp_last;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample outputs 1 ns after the edge, then drive the transmitter model
  task automatic step();
    @(posedge clk125M);
    #1;
    cyc++;
    if (capture_done) cd_count++;
    if (tx_en_pulse) begin
      launch_q.push_back(32'(tx_length));
      launch_cyc_q.push_back(cyc);
      if (last_done >= 0 && (cyc - last_done) < min_gap) min_gap = cyc - last_done;
      if (resp_en) resp_cnt = resp_delay;
    end
    if (resp_en) begin
      tx_done = 1'b0;
      if (resp_cnt == 0) begin
        tx_done   = 1'b1;
        last_done = cyc + 1;
        resp_cnt  = -1;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
      end
    end
  endtask

  task automatic clear_log();
    launch_q.delete();
    launch_cyc_q.delete();
    cd_count  = 0;
    last_done = -1;
    min_gap   = 1000000;
  endtask

  task automatic pulse_restart();
    restart_req = 1'b1;
    step();
    step();
    restart_req = 1'b0;
  endtask

  // Reference: even byte count cut into MAXP-sized packets, remainder last
  task automatic model_split(input int unsigned total);
    int unsigned rem;
    int unsigned c;
    exp_q.delete();
    rem = total - (total % 2);
    while (rem != 0) begin
      c = (rem > MAXP) ? MAXP : rem;
      exp_q.push_back(c);
      rem -= c;
    end
  endtask

  task automatic wait_cd(input int budget, input string name);
    int n;
    n = 0;
    while (cd_count == 0 && n < budget) begin
      step();
      n++;
    end
    check({name, " capture_done_in_time"}, longint'(cd_count > 0), 1);
  endtask

  task automatic run_capture(input int unsigned total, input int unsigned fifo, input string name);
    total_bytes   = total;
    fifo_rd_count = CNTW'(fifo);
    fifo_empty    = (fifo == 0);
    clear_log();
    model_split(total);
    pulse_restart();
    if (exp_q.size() != 0) check({name, " busy"}, busy, 1);
    wait_cd(exp_q.size() * 80 + 100, name);
    repeat (40) step();
    check({name, " npkts"}, launch_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < launch_q.size(); i++)
      check($sformatf("%s len[%0d]", name, i), launch_q[i], exp_q[i]);
    check({name, " pkt_count"}, pkt_count, exp_q.size() % 65536);
    check({name, " capture_done_count"}, cd_count, 1);
    check({name, " busy_end"}, busy, 0);
    if (exp_q.size() > 1) check({name, " ifg_respected"}, longint'(min_gap >= IFG), 1);
  endtask

  initial begin
    int n;
    int l;
    int e;
    n_cmp = 0; n_bad = 0; cyc = 0;
    resp_en = 1'b0; resp_delay = 3; resp_cnt = -1;
    reset_n = 1'b0; restart_req = 1'b0; total_bytes = '0;
    fifo_rd_count = '0; fifo_empty = 1'b1; tx_done = 1'b0;
    clear_log();

    vecs[0] = '{total: 4000, fifo: 4000, exp_pkts: 3, exp_last: 1056};
    vecs[1] = '{total: 1472, fifo: 1500, exp_pkts: 1, exp_last: 1472};
    vecs[2] = '{total: 1473, fifo: 1473, exp_pkts: 1, exp_last: 1472};
    vecs[3] = '{total: 1474, fifo: 2000, exp_pkts: 2, exp_last: 2};
    vecs[4] = '{total: 2944, fifo: 3000, exp_pkts: 2, exp_last: 1472};
    vecs[5] = '{total: 3,    fifo: 3,    exp_pkts: 1, exp_last: 2};

    // Reset values
    repeat (3) step();
    check("rst tx_en_pulse", tx_en_pulse, 0);
    check("rst tx_length", tx_length, 0);
    check("rst busy", busy, 0);
    check("rst capture_done", capture_done, 0);
    check("rst tx_err", tx_err, 0);
    check("rst pkt_count", pkt_count, 0);
    reset_n = 1'b1;
    step();

    // tx_done while idle is ignored
    clear_log();
    tx_done = 1'b1; step(); tx_done = 1'b0; step(); step();
    check("idle txdone pkt_count", pkt_count, 0);
    check("idle txdone capture_done", cd_count, 0);
    check("idle txdone busy", busy, 0);

    // total_bytes = 1: forced to zero, completes without a packet
    clear_log();
    total_bytes = 1; restart_req = 1'b1;
    step(); check("zero cd@0", capture_done, 0);
    step(); restart_req = 1'b0; check("zero cd@1", capture_done, 0); check("zero busy@1", busy, 0);
    step(); check("zero cd@2", capture_done, 1); check("zero busy@2", busy, 0);
    step(); check("zero cd@3", capture_done, 0);
    repeat (30) step();
    check("zero no launch", launch_q.size(), 0);
    check("zero cd count", cd_count, 1);
    check("zero pkt_count", pkt_count, 0);

    // Table-driven captures with ample FIFO data
    resp_en = 1'b1;
    foreach (vecs[i]) begin
      resp_delay = 2 + i;
      run_capture(vecs[i].total, vecs[i].fifo, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table npkts", i), launch_q.size(), vecs[i].exp_pkts);
      if (launch_q.size() > 0)
        check($sformatf("vec%0d table last_len", i), launch_q[launch_q.size()-1], vecs[i].exp_last);
    end

    // Randomised captures against the reference model
    for (int r = 0; r < 6; r++) begin
      resp_delay = int'($urandom_range(20, 1));
      run_capture($urandom_range(5000, 2), 16000, $sformatf("rnd%0d", r));
    end

    // Partial flush after timeout, then full remainder
    resp_delay = 4;
    total_bytes = 1000; fifo_rd_count = CNTW'(301); fifo_empty = 1'b0;
    clear_log();
    e = cyc + 1;
    pulse_restart();
    n = 0;
    while (launch_q.size() == 0 && n < int'(FLUSH_TO) + 100) begin step(); n++; end
    check("flush launch", launch_q.size(), 1);
    if (launch_q.size() > 0) begin
      check("flush len", launch_q[0], 300);
      check("flush wait", longint'((launch_cyc_q[0] - e) >= int'(FLUSH_TO) &&
                                   (launch_cyc_q[0] - e) <= int'(FLUSH_TO) + 5), 1);
    end
    fifo_rd_count = CNTW'(700);
    wait_cd(400, "flush");
    check("flush npkts", launch_q.size(), 2);
    if (launch_q.size() > 1) check("flush len2", launch_q[1], 700);
    check("flush pkt_count", pkt_count, 2);

    // Restart while a packet is in flight: deferred until tx_done
    resp_en = 1'b0; tx_done = 1'b0;
    total_bytes = 1472; fifo_rd_count = CNTW'(16000); fifo_empty = 1'b0;
    clear_log();
    pulse_restart();
    n = 0;
    while (launch_q.size() == 0 && n < 20) begin step(); n++; end
    check("pend launch", launch_q.size(), 1);
    total_bytes = 2000; restart_req = 1'b1;
    step(); step(); restart_req = 1'b0;
    repeat (48) step();
    check("pend busy_in_flight", busy, 1);
    tx_done = 1'b1; step(); tx_done = 1'b0;
    step(); step(); step();
    check("pend no capture_done", cd_count, 0);
    check("pend pkt_count", pkt_count, 0);
    check("pend busy", busy, 1);
    check("pend relaunch", launch_q.size(), 2);
    if (launch_q.size() > 1) check("pend new len", launch_q[1], 1472);
    resp_en = 1'b1; resp_delay = 3;
    // Responder missed the relaunch; answer it by hand
    tx_done = 1'b1; step(); tx_done = 1'b0;
    wait_cd(200, "pend");
    check("pend npkts", launch_q.size(), 3);
    if (launch_q.size() > 2) check("pend last len", launch_q[2], 528);
    check("pend final pkt_count", pkt_count, 2);
    check("pend cd count", cd_count, 1);

    // Transmitter never answers: timeout fault, then restart clears it
    resp_en = 1'b0; tx_done = 1'b0;
    total_bytes = 100; fifo_rd_count = CNTW'(200);
    clear_log();
    pulse_restart();
    n = 0;
    while (launch_q.size() == 0 && n < 20) begin step(); n++; end
    check("to launch", launch_q.size(), 1);
    l = (launch_q.size() > 0) ? launch_cyc_q[0] : cyc;
    n = 0;
    while (!tx_err && n < int'(TX_TO) + 50) begin step(); n++; end
    check("to tx_err", tx_err, 1);
    check("to latency", longint'((cyc - l) >= int'(TX_TO) && (cyc - l) <= int'(TX_TO) + 5), 1);
    check("to busy", busy, 0);
    repeat (20) step();
    check("to no relaunch", launch_q.size(), 1);
    check("to tx_err sticky", tx_err, 1);
    resp_en = 1'b1; resp_delay = 3;
    clear_log();
    pulse_restart();
    check("to err cleared", tx_err, 0);
    wait_cd(200, "to_recover");
    check("to recover pkt_count", pkt_count, 1);

    // Asynchronous reset while in LAUNCH
    resp_delay = 5; total_bytes = 500; fifo_rd_count = CNTW'(1000);
    clear_log();
    pulse_restart();
    n = 0;
    while (!tx_en_pulse && n < 20) begin step(); n++; end
    check("rst launch seen", tx_en_pulse, 1);
    reset_n = 1'b0;
    #1;
    check("rst launch tx_en_pulse", tx_en_pulse, 0);
    check("rst launch busy", busy, 0);
    check("rst launch tx_length", tx_length, 0);
    check("rst launch pkt_count", pkt_count, 0);
    resp_en = 1'b0; resp_cnt = -1; tx_done = 1'b0;
    #1 reset_n = 1'b1;
    repeat (5) step();
    check("post rst busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

endmodule
